// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/write-back sequencing
// with memory wait timeout, illegal-opcode trap and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        regdest,
  output logic        regwrite,
  output logic        alusrc,
  output logic [1:0]  alu_op,
  output logic        memtoreg,
  output logic        illegal,
  output logic        timeout,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int unsigned           WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [5:0]          opc_q, opc_d;
  logic [WAIT_W-1:0]   wait_q, wait_d, wait_inc;
  logic [15:0]         instr_cnt_q, instr_cnt_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  logic                retire;

  // NOTE: state lives only in always_ff with non-blocking assignments so every
  // flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      opc_q       <= '0;
      wait_q      <= '0;
      instr_cnt_q <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      wait_q      <= wait_d;
      instr_cnt_q <= instr_cnt_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
    end
  end

  assign wait_inc = wait_q + 1'b1;

  // NOTE: every signal written below gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    wait_d    = wait_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    regdest   = 1'b0;
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    alu_op    = 2'b00;
    memtoreg  = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_inc == WAIT_MAX) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        unique case (opc_q)
          OP_RTYPE: begin alu_op = 2'b10; state_d = S_WB; end
          OP_ADDI:  begin alusrc = 1'b1;  state_d = S_WB; end
          OP_LW, OP_SW: begin alusrc = 1'b1; state_d = S_MEM; end
          OP_BEQ: begin
            alu_op = 2'b01;
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opc_q == OP_SW);
        if (mem_ready) begin
          state_d = (opc_q == OP_SW) ? S_FETCH : S_WB;
        end else if (wait_inc == WAIT_MAX) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        regdest  = (opc_q == OP_RTYPE);
        memtoreg = (opc_q == OP_LW);
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    if (state_d != state_q) wait_d = '0;

    // Reset also silences the decoded strobes, since FETCH would otherwise drive mem_req.
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = 2'b00;
      regdest  = 1'b0;
      regwrite = 1'b0;
      alusrc   = 1'b0;
      alu_op   = 2'b00;
      memtoreg = 1'b0;
    end
  end

  assign retire      = (state_d == S_FETCH) &&
                       (state_q inside {S_EXEC, S_MEM, S_WB});
  assign instr_cnt_d = retire ? instr_cnt_q + 16'd1 : instr_cnt_q;

  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign state       = state_q;
  assign instr_count = instr_cnt_q;

endmodule
